// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter that time-shares one combinational multiplier between NUM_REQ requesters.
// Optional completed-operation counter enabled by defining MUL_SHARE_ARBITER_STATS_EN.

module n_bit_mul #(
    parameter int BIT_DEPTH = 32
) (
    input  logic [BIT_DEPTH-1:0]   a,
    input  logic [BIT_DEPTH-1:0]   b,
    output logic [2*BIT_DEPTH-1:0] c
);
    assign c = (2*BIT_DEPTH)'(a) * (2*BIT_DEPTH)'(b);
endmodule

module mul_share_arbiter #(
    parameter int BIT_DEPTH = 32,
    parameter int NUM_REQ   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*BIT_DEPTH-1:0]   req_a,
    input  logic [NUM_REQ*BIT_DEPTH-1:0]   req_b,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [2*BIT_DEPTH-1:0]         rsp_c,
    output logic [$clog2(NUM_REQ)-1:0]     rsp_id,
    output logic                           busy,
    output logic [15:0]                    op_count
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t                 state, next_state;
    logic [ID_W-1:0]        rr_ptr;
    logic [ID_W-1:0]        cur_id;
    logic [ID_W-1:0]        win_id;
    logic                   found;
    logic                   grant;
    logic [BIT_DEPTH-1:0]   op_a, op_b;
    logic [2*BIT_DEPTH-1:0] product;

    n_bit_mul #(.BIT_DEPTH(BIT_DEPTH)) u_mul (
        .a (op_a),
        .b (op_b),
        .c (product)
    );

    // Search from rr_ptr upward with wrap; NUM_REQ need not be a power of two.
    always_comb begin
        int unsigned idx;
        logic [ID_W-1:0] cand;
        found  = 1'b0;
        win_id = '0;
        idx    = 0;
        cand   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx  = (32'(rr_ptr) + k) % 32'(NUM_REQ);
            cand = ID_W'(idx);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                win_id = cand;
            end
        end
    end

    assign grant = (state == IDLE) && found && !rst;
    assign busy  = (state != IDLE);

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[win_id] = 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant) next_state = CALC;
            CALC:    next_state = RESP;
            RESP:    if (rsp_valid && rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            cur_id    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            rsp_valid <= 1'b0;
            rsp_c     <= '0;
            rsp_id    <= '0;
        end else begin
            if (grant) begin
                op_a   <= req_a[win_id*BIT_DEPTH +: BIT_DEPTH];
                op_b   <= req_b[win_id*BIT_DEPTH +: BIT_DEPTH];
                cur_id <= win_id;
                rr_ptr <= (win_id == ID_W'(NUM_REQ-1)) ? '0 : win_id + 1'b1;
            end
            if (state == CALC) begin
                rsp_c     <= product;
                rsp_id    <= cur_id;
                rsp_valid <= 1'b1;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef MUL_SHARE_ARBITER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count <= '0;
        end else if (rsp_valid && rsp_ready && op_count != '1) begin
            op_count <= op_count + 16'd1;
        end
    end
`else
    assign op_count = 16'h0000;
`endif

endmodule
